// File: rtl/mmio_pkg.sv
// Address map constants for the MIPS150 memory-mapped I/O region.
package mmio_pkg;

    localparam logic [3:0]  MMIO_NIBBLE = 4'h8;
    localparam int unsigned CH_STRIDE   = 16;

    localparam logic [3:0]  RX_STAT = 4'h0;
    localparam logic [3:0]  TX_STAT = 4'h4;
    localparam logic [3:0]  TX_DATA = 4'h8;
    localparam logic [3:0]  RX_DATA = 4'hC;

    localparam logic [27:0] CNT_BASE    = 28'h000_0100;
    localparam logic [3:0]  CNT_CYCLE   = 4'h0;
    localparam logic [3:0]  CNT_INSTRET = 4'h4;
    localparam logic [3:0]  CNT_CLEAR   = 4'h8;

    // Region-relative address of a counter register.
    function automatic logic [27:0] cnt_addr(input logic [3:0] off);
        return CNT_BASE | 28'(off);
    endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Byte-wide receive FIFO; contents are discarded on reset by clearing the pointers.
module mmio_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: UART channels, cycle/instret counters and a registered read port.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_UART = 1,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  is_mmio,
    input  logic                  inst_retire,
    output logic [8*NUM_UART-1:0] uart_tx_data,
    output logic [NUM_UART-1:0]   uart_tx_valid,
    input  logic [NUM_UART-1:0]   uart_tx_ready,
    input  logic [8*NUM_UART-1:0] uart_rx_data,
    input  logic [NUM_UART-1:0]   uart_rx_valid,
    output logic [NUM_UART-1:0]   uart_rx_ready
);

    logic                live;
    logic                rd_live;
    logic                wr_live;
    logic                ch_space;
    logic                cnt_clear;
    logic [3:0]          ch_idx;
    logic [3:0]          reg_off;
    logic [NUM_UART-1:0] ch_sel;
    logic [NUM_UART-1:0] fifo_full;
    logic [NUM_UART-1:0] fifo_empty;
    logic [NUM_UART-1:0] fifo_push;
    logic [NUM_UART-1:0] fifo_pop;
    logic [7:0]          fifo_dout [NUM_UART];
    logic [NUM_UART-1:0] tx_pending;
    logic [7:0]          tx_byte [NUM_UART];
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    instret_cnt;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign is_mmio   = (cpu_addr[31:28] == MMIO_NIBBLE);
    assign live      = is_mmio & (cpu_we | cpu_re) & ~stall;
    assign rd_live   = live & cpu_re;
    assign wr_live   = live & cpu_we;
    // Channel registers live only in the first 256 bytes of the region.
    assign ch_space  = (cpu_addr[27:8] == 20'h0);
    assign ch_idx    = 4'(cpu_addr[7:0] / 8'(CH_STRIDE));
    assign reg_off   = cpu_addr[3:0];
    assign cnt_clear = wr_live & (cpu_addr[27:0] == cnt_addr(CNT_CLEAR));

    assign unused_wdata = ^cpu_wdata[31:8];

    for (genvar g = 0; g < NUM_UART; g++) begin : g_ch
        assign ch_sel[g]    = ch_space & (ch_idx == 4'(g));
        assign fifo_push[g] = uart_rx_valid[g] & ~fifo_full[g];
        assign fifo_pop[g]  = rd_live & ch_sel[g] & (reg_off == RX_DATA) & ~fifo_empty[g];

        mmio_rx_fifo #(
            .DEPTH (RX_DEPTH)
        ) u_rx_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (uart_rx_data[8*g +: 8]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .dout  (fifo_dout[g])
        );

        assign uart_rx_ready[g]       = ~fifo_full[g];
        assign uart_tx_valid[g]       = tx_pending[g];
        assign uart_tx_data[8*g +: 8] = tx_byte[g];
    end

    // TX holding registers: a write is only taken when nothing is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pending <= '0;
            for (int ch = 0; ch < NUM_UART; ch++) begin
                tx_byte[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_UART; ch++) begin
                if (wr_live && ch_sel[ch] && (reg_off == TX_DATA) && !tx_pending[ch]) begin
                    tx_pending[ch] <= 1'b1;
                    tx_byte[ch]    <= cpu_wdata[7:0];
                end else if (tx_pending[ch] && uart_tx_ready[ch]) begin
                    tx_pending[ch] <= 1'b0;
                end
            end
        end
    end

    // Counters; a clear overrides the same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (cnt_clear) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (inst_retire && !stall) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int ch = 0; ch < NUM_UART; ch++) begin
            if (ch_sel[ch]) begin
                case (reg_off)
                    RX_STAT: rd_mux = {31'h0, !fifo_empty[ch]};
                    TX_STAT: rd_mux = {31'h0, (!tx_pending[ch] && uart_tx_ready[ch])};
                    RX_DATA: rd_mux = fifo_empty[ch] ? 32'h0 : {24'h0, fifo_dout[ch]};
                    default: rd_mux = '0;
                endcase
            end
        end
        if (cpu_addr[27:0] == cnt_addr(CNT_CYCLE)) begin
            rd_mux = 32'(cycle_cnt);
        end else if (cpu_addr[27:0] == cnt_addr(CNT_INSTRET)) begin
            rd_mux = 32'(instret_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if (rd_live) begin
            cpu_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed table, hand sequences, randomized model comparison.
module tb_mmio_ctrl;

    localparam int unsigned NU    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic [31:0]   cpu_addr;
    logic          cpu_we;
    logic          cpu_re;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          is_mmio;
    logic          inst_retire;
    logic [8*NU-1:0] uart_tx_data;
    logic [NU-1:0] uart_tx_valid;
    logic [NU-1:0] uart_tx_ready;
    logic [8*NU-1:0] uart_rx_data;
    logic [NU-1:0] uart_rx_valid;
    logic [NU-1:0] uart_rx_ready;

    mmio_ctrl #(.NUM_UART(NU), .RX_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .cpu_addr      (cpu_addr),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .is_mmio       (is_mmio),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
        inst_retire = 0; uart_rx_valid = '0; uart_rx_data = '0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1;
        cyc();
        cpu_we = 0; cpu_addr = '0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        cpu_addr = a; cpu_re = 1;
        cyc();
        cpu_re = 0; cpu_addr = '0;
        check(name, cpu_rdata, exp);
    endtask

    // Directed vectors; rx stimulus is on channel 0 only, one record per clock.
    typedef struct {
        logic        we, re;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic        rxv;
        logic [7:0]  rxd;
        logic [1:0]  txr;
        logic [31:0] e_rd;
        logic [1:0]  e_rdy, e_tv;
        logic [7:0]  e_td0, e_td1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                                input logic [1:0] txr, input logic [31:0] e_rd,
                                input logic [1:0] e_rdy, input logic [1:0] e_tv,
                                input logic [7:0] e_td0, input logic [7:0] e_td1);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.rxv = rxv; v.rxd = rxd;
        v.txr = txr; v.e_rd = e_rd; v.e_rdy = e_rdy; v.e_tv = e_tv;
        v.e_td0 = e_td0; v.e_td1 = e_td1;
        return v;
    endfunction

    // Behavioural reference for the randomized phase.
    logic [7:0]  mq [NU][$];
    logic        m_pend [NU];
    logic [7:0]  m_txb [NU];
    logic [31:0] m_cyc, m_ins, m_rd;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [27:0] o;
        int ch, off;
        o = a[27:0];
        if (o == 28'h100) return m_cyc;
        if (o == 28'h104) return m_ins;
        if (o >= 28'h100) return 32'h0;
        ch  = int'(o) / 16;
        off = int'(o) % 16;
        if (ch >= NU) return 32'h0;
        case (off)
            0:  return (mq[ch].size() > 0) ? 32'h1 : 32'h0;
            4:  return (!m_pend[ch] && uart_tx_ready[ch]) ? 32'h1 : 32'h0;
            12: return (mq[ch].size() > 0) ? {24'h0, mq[ch][0]} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic live;
        logic [31:0] base;
        logic hs, acc, pop, push;
        live = (cpu_addr[31:28] == 4'h8) && (cpu_we || cpu_re) && !stall;
        if (live && cpu_re) m_rd = model_read(cpu_addr);
        for (int c = 0; c < NU; c++) begin
            base = 32'h8000_0000 + 32'(16 * c);
            hs   = m_pend[c] && uart_tx_ready[c];
            acc  = live && cpu_we && (cpu_addr == base + 32'h8) && !m_pend[c];
            pop  = live && cpu_re && (cpu_addr == base + 32'hC) && (mq[c].size() > 0);
            push = uart_rx_valid[c] && (mq[c].size() < DEPTH);
            if (acc) begin
                m_pend[c] = 1'b1;
                m_txb[c]  = cpu_wdata[7:0];
            end
            if (hs) m_pend[c] = 1'b0;
            if (pop) void'(mq[c].pop_front());
            if (push) mq[c].push_back(uart_rx_data[8*c +: 8]);
        end
        if (live && cpu_we && cpu_addr == 32'h8000_0108) begin
            m_cyc = '0;
            m_ins = '0;
        end else begin
            m_cyc = m_cyc + 32'h1;
            if (inst_retire && !stall) m_ins = m_ins + 32'h1;
        end
    endtask

    logic [31:0] alist [15] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                                32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C,
                                32'h8000_0020, 32'h8000_002C, 32'h8000_0100, 32'h8000_0104,
                                32'h8000_0108, 32'h8000_1000, 32'h1000_0000};

    initial begin
        rst_n = 1'b0;
        uart_tx_ready = '0;
        idle_inputs();

        // Reset then idle: cycle counter, idle handshake outputs.
        do_reset();
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst_tx_data", 32'(uart_tx_data), 32'h0);
        check("rst_rx_ready", 32'(uart_rx_ready), 32'h3);
        repeat (10) cyc();
        rd_chk("cycle_after_10", 32'h8000_0100, 32'd10);

        // Instret with stalls, then clear racing an increment.
        wr(32'h8000_0108, 32'h0);
        for (int i = 0; i < 5; i++) begin
            inst_retire = 1;
            stall = (i == 1 || i == 3);
            cyc();
        end
        inst_retire = 0; stall = 0;
        rd_chk("instret_3", 32'h8000_0104, 32'd3);
        inst_retire = 1;
        wr(32'h8000_0108, 32'hDEAD_BEEF);
        inst_retire = 0;
        rd_chk("instret_cleared", 32'h8000_0104, 32'd0);
        rd_chk("cycle_cleared", 32'h8000_0100, 32'd1);

        // Stalled accesses have no side effects and leave rdata held.
        stall = 1;
        wr(32'h8000_0008, 32'h99);
        check("stall_no_tx", 32'(uart_tx_valid), 32'h0);
        rd_chk("stall_rd_hold", 32'h8000_0104, 32'd1);
        stall = 0;

        do_reset();
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h10,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h20,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h30,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h40,2'b00, 32'h00,2'b10,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h50,2'b00, 32'h00,2'b10,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_0000,8'h00,0,8'h00,2'b00, 32'h01,2'b10,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h10,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h20,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h30,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h40,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_0000,8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(1,0,32'h8000_0008,8'h41,0,8'h00,2'b00, 32'h00,2'b11,2'b01,8'h41,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b01,8'h41,8'h00));
        tbl.push_back(mk(1,0,32'h8000_0008,8'h42,0,8'h00,2'b00, 32'h00,2'b11,2'b01,8'h41,8'h00));
        tbl.push_back(mk(0,1,32'h8000_0004,8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b01,8'h41,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,0,8'h00,2'b01, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_0004,8'h00,0,8'h00,2'b01, 32'h01,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h11,2'b00, 32'h01,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h22,2'b00, 32'h01,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,1,8'h33,2'b00, 32'h11,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h44,2'b00, 32'h11,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,0,32'h0,        8'h00,1,8'h55,2'b00, 32'h11,2'b10,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,1,8'h66,2'b00, 32'h22,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h33,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h44,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h55,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(0,1,32'h8000_000C,8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b00,8'h00,8'h00));
        tbl.push_back(mk(1,0,32'h8000_0018,8'h77,0,8'h00,2'b00, 32'h00,2'b11,2'b10,8'h00,8'h77));
        tbl.push_back(mk(0,1,32'h8000_0014,8'h00,0,8'h00,2'b00, 32'h00,2'b11,2'b10,8'h00,8'h77));
        tbl.push_back(mk(0,1,32'h8000_0004,8'h00,0,8'h00,2'b01, 32'h01,2'b11,2'b10,8'h00,8'h77));
        tbl.push_back(mk(0,1,32'h8000_0020,8'h00,0,8'h00,2'b01, 32'h00,2'b11,2'b10,8'h00,8'h77));

        foreach (tbl[i]) begin
            cpu_we = tbl[i].we; cpu_re = tbl[i].re; cpu_addr = tbl[i].addr;
            cpu_wdata = {24'h0, tbl[i].wd};
            uart_rx_valid = {1'b0, tbl[i].rxv}; uart_rx_data = {8'h00, tbl[i].rxd};
            uart_tx_ready = tbl[i].txr;
            cyc();
            check($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].e_rd);
            check($sformatf("tbl%0d_rx_ready", i), 32'(uart_rx_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_tx_valid", i), 32'(uart_tx_valid), 32'(tbl[i].e_tv));
            if (tbl[i].e_tv[0]) check($sformatf("tbl%0d_tx_data0", i), 32'(uart_tx_data[7:0]), 32'(tbl[i].e_td0));
            if (tbl[i].e_tv[1]) check($sformatf("tbl%0d_tx_data1", i), 32'(uart_tx_data[15:8]), 32'(tbl[i].e_td1));
        end
        idle_inputs();

        // Asynchronous reset with channel 1 still holding a byte.
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("async_rst_rx_ready", 32'(uart_rx_ready), 32'h3);
        check("async_rst_rdata", cpu_rdata, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Randomized run against the reference model.
        uart_tx_ready = '0;
        do_reset();
        for (int c = 0; c < NU; c++) begin
            mq[c].delete();
            m_pend[c] = 1'b0;
            m_txb[c]  = 8'h0;
        end
        m_cyc = '0; m_ins = '0; m_rd = '0;
        for (int k = 0; k < 3000; k++) begin
            int op;
            cpu_addr  = alist[$urandom_range(14, 0)];
            op        = int'($urandom_range(3, 0));
            cpu_we    = (op == 1 || op == 3);
            cpu_re    = (op == 2 || op == 3);
            if (cpu_addr == 32'h8000_0108 && $urandom_range(7, 0) != 0) cpu_we = 0;
            cpu_wdata = $urandom;
            stall     = ($urandom_range(7, 0) == 0);
            inst_retire   = $urandom_range(1, 0) == 1;
            uart_tx_ready = NU'($urandom);
            uart_rx_valid = NU'($urandom);
            uart_rx_data  = (8*NU)'($urandom);
            #1;
            check("rnd_is_mmio", 32'(is_mmio), 32'(cpu_addr[31:28] == 4'h8));
            for (int c = 0; c < NU; c++) begin
                check($sformatf("rnd%0d_rx_ready%0d", k, c), 32'(uart_rx_ready[c]), 32'(mq[c].size() < DEPTH));
                check($sformatf("rnd%0d_tx_valid%0d", k, c), 32'(uart_tx_valid[c]), 32'(m_pend[c]));
                if (m_pend[c]) check($sformatf("rnd%0d_tx_data%0d", k, c), 32'(uart_tx_data[8*c +: 8]), 32'(m_txb[c]));
            end
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rnd%0d_rdata", k), cpu_rdata, m_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
